uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Packet-granular round-robin arbiter that shares the single UART transmitter between several on-chip requesters. Each requester streams bytes with a valid/ready/last handshake. The arbiter locks the grant for a whole packet and writes bytes into the UART TX FIFO through `wr_uart`/`w_data`, honouring `tx_full`. It sits between client logic and the `uart` block and replaces the hard-tied `wr_uart` in the top level.

## Interface
- `NREQ`, 4, number of requesters, 2..16
- `DATA_WIDTH`, 8, byte width, equal to uart `DBIT`
- `TIMEOUT`, 1024, idle-cycle limit for a granted requester mid-packet; 0 disables the watchdog
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-low (asserted when 0)
- `req_valid`  in  NREQ  per-requester byte valid
- `req_data`  in  NREQ*DATA_WIDTH  per-requester byte; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_last`  in  NREQ  marks the final byte of a packet
- `req_ready`  out  NREQ  per-requester accept
- `tx_full`  in  1  UART TX FIFO full
- `wr_uart`  out  1  UART TX FIFO write strobe
- `w_data`  out  DATA_WIDTH  byte to the UART
- `busy`  out  1  a packet is granted
- `grant_id`  out  max(1,$clog2(NREQ))  current or last granted requester
- `abort_pulse`  out  1  one-cycle pulse on watchdog release

## Operation
- FSM states: IDLE, HDR (only with the macro), XFER.
- IDLE:
  - If any `req_valid` is high, pick the first requester at or after `ptr+1`, wrapping modulo NREQ.
  - Register the pick into `grant_id` and go to HDR or XFER.
  - `req_ready` = 0 and `wr_uart` = 0.
- XFER, with g = `grant_id`:
  - `req_ready[g]` = !`tx_full`; every other `req_ready` bit = 0.
  - Transfer occurs when `req_valid[g] && req_ready[g]`.
  - `wr_uart` = transfer, combinational. `w_data` = slice g of `req_data`.
  - When the transfer carries `req_last[g]`: go to IDLE and set `ptr` = g.
- Watchdog (TIMEOUT>0):
  - The counter clears on entry to XFER and on every transfer.
  - It increments each XFER cycle with `req_valid[g]` = 0.
  - It holds while `tx_full` stalls a valid byte.
  - When the count reaches TIMEOUT: `abort_pulse` = 1 for one cycle, `ptr` = g, next state IDLE, no write that cycle.
- `busy` = state != IDLE. `grant_id` holds its value in IDLE.
- `req_valid` from non-granted requesters is ignored. Requesters must hold data stable while valid and not ready.

## Timing
- Reset values: state IDLE, `ptr` = NREQ-1 (requester 0 wins first), `grant_id` 0, `busy` 0, `wr_uart` 0, `req_ready` 0, `abort_pulse` 0, watchdog 0.
- Grant latency: request seen in IDLE at cycle n → first byte accepted at cycle n+1 (n+2 with header), provided `tx_full` = 0.
- Throughput: one byte per cycle while valid and not full. One IDLE bubble between packets.
- Single-byte packet: `req_last` on the first transfer → IDLE next cycle.
- `tx_full` high: no write and no transfer; the byte is held by the requester.
- Simultaneous requests: rotating priority guarantees each requester waits at most NREQ-1 packets.
- Reset mid-packet: outputs drop on the next edge with no further writes. Bytes already in the UART FIFO are not recalled.
- Requester deasserts valid mid-packet with TIMEOUT=0: the grant is held indefinitely.

## Configuration
- `UART_ARB_HDR_EN` defined:
  - After the grant, the HDR state writes one header byte {4'hA, grant_id[3:0]} when `tx_full` = 0, then enters XFER.
  - Requires DATA_WIDTH = 8.
  - No `req_ready` during HDR.
  - The watchdog does not run in HDR.
- Undefined: the HDR state is absent; IDLE goes directly to XFER.

## Structure
- Shared package `uart_pkg`:
  - `arb_state_t` enum (IDLE, HDR, XFER)
  - `HDR_MAGIC` = 4'hA
  - a grant-width function
- Sub-module `uart_rr_pick`: combinational rotating-priority selector. Inputs: request vector and pointer. Outputs: `found` and `index`.

## Test plan
- Single requester, `req_valid[1]`, 3-byte packet 0x41, 0x42, 0x43 (last on 0x43), `tx_full` = 0 → `wr_uart` high on 3 consecutive cycles starting the cycle after the grant; `w_data` 0x41, 0x42, 0x43; `busy` falls after 0x43.
- All 4 requesters request 1-byte packets continuously from reset → grant order 0, 1, 2, 3, 0; one IDLE cycle between packets.
- `tx_full` asserted for 5 cycles mid-packet → no `wr_uart`, `req_ready[g]` = 0, byte held, no abort; resumes when `tx_full` drops.
- TIMEOUT = 8; requester 2 sends 1 byte without last, then drops valid → `abort_pulse` exactly 8 cycles after the last transfer; next grant goes to requester 3 if it is requesting.
- `rst` driven low for one cycle during XFER → next cycle all outputs at reset values; requester 0 gets the next grant.
- With `UART_ARB_HDR_EN`, requester 3 sends packet 0x55 → UART receives 0xA3 then 0x55.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, header magic and grant-width helper for the UART TX arbiter
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    XFER = 2'd2
  } arb_state_t;

  localparam logic [3:0] HDR_MAGIC = 4'hA;

  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational rotating-priority selector, first request at or after ptr+1
module uart_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   index
);

  // Scan from the farthest candidate down so the nearest one after ptr wins.
  always_comb begin
    logic [IW-1:0] j;
    j     = '0;
    found = 1'b0;
    index = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = IW'((int'(ptr) + k) % NREQ);
      if (req[j]) begin
        found = 1'b1;
        index = j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin arbiter feeding the UART TX FIFO
// Optional header byte per packet when UART_ARB_HDR_EN is defined.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]            req_last,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       tx_full,
  output logic                       wr_uart,
  output logic [DATA_WIDTH-1:0]      w_data,
  output logic                       busy,
  output logic [grant_width(NREQ)-1:0] grant_id,
  output logic                       abort_pulse
);

  localparam int GW  = grant_width(NREQ);
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t     state_q, state_d;
  logic [GW-1:0]  ptr_q, ptr_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [WDW-1:0] wd_q, wd_d;

  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic          valid_g;
  logic          last_g;
  logic          xfer;

  uart_rr_pick #(
    .NREQ(NREQ),
    .IW  (GW)
  ) u_pick (
    .req  (req_valid),
    .ptr  (ptr_q),
    .found(pick_found),
    .index(pick_idx)
  );

  assign valid_g  = req_valid[grant_q];
  assign last_g   = req_last[grant_q];
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= GW'(NREQ - 1);
      grant_q <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      wd_q    <= wd_d;
    end
  end

  // Strobes are qualified by rst so a reset cycle never pushes a byte into the FIFO.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    wd_d        = wd_q;
    req_ready   = '0;
    wr_uart     = 1'b0;
    abort_pulse = 1'b0;
    xfer        = 1'b0;
    w_data      = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          wd_d    = '0;
`ifdef UART_ARB_HDR_EN
          state_d = HDR;
`else
          state_d = XFER;
`endif
        end
      end
`ifdef UART_ARB_HDR_EN
      HDR: begin
        w_data = {HDR_MAGIC, 4'(grant_q)};
        if (!tx_full) begin
          wr_uart = rst;
          wd_d    = '0;
          state_d = XFER;
        end
      end
`endif
      XFER: begin
        req_ready[grant_q] = !tx_full && rst;
        xfer               = valid_g && !tx_full;
        wr_uart            = xfer && rst;
        if (xfer) begin
          wd_d = '0;
          if (last_g) begin
            state_d = IDLE;
            ptr_d   = grant_q;
          end
        end else if (TIMEOUT > 0 && !valid_g) begin
          // A stalled-by-full byte keeps the count frozen; only an empty requester ages.
          if (wd_q == WDW'(TIMEOUT - 1)) begin
            abort_pulse = rst;
            state_d     = IDLE;
            ptr_d       = grant_q;
            wd_d        = '0;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
